branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/btb_if.sv | 28 ++
 rtl/branch_target_buffer.sv | 99 +++++++++
 2 files changed

// File: rtl/btb_if.sv
// Fetch/execute-side signal bundle between the CPU pipeline and the branch target buffer.
// The master modport is the pipeline; the slave modport is the predictor.
interface btb_if;
    logic [31:0] PCF;
    logic        StallD;
    logic        FlushD;
    logic        StallE;
    logic        FlushE;
    logic        BranchTypeE;
    logic        BranchE;
    logic [31:0] PCE;
    logic [31:0] BrTargetE;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        BranchPredictedE;

    modport master (
        output PCF, StallD, FlushD, StallE, FlushE,
        output BranchTypeE, BranchE, PCE, BrTargetE,
        input  PredTakenF, PredTargetF, BranchPredictedE
    );

    modport slave (
        input  PCF, StallD, FlushD, StallE, FlushE,
        input  BranchTypeE, BranchE, PCE, BrTargetE,
        output PredTakenF, PredTargetF, BranchPredictedE
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, a combinational
// fetch-stage lookup and an E-stage training port; the prediction follows the branch to E.
module branch_target_buffer #(
    parameter int ENTRIES = 64
) (
    input logic   clk,
    input logic   CpuRstN,
    btb_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_cnt    [ENTRIES];
    logic             r_pred_d;
    logic             r_pred_e;

    logic [IDX_W-1:0] w_idx_f;
    logic [TAG_W-1:0] w_tag_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_e;
    logic             w_hit_f;
    logic             w_pred_f;
    logic             w_hit_e;
    logic             w_upd;
    logic             w_wr_data;
    logic             w_unused_pc;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Word-aligned PCs: the two low bits never participate in indexing or tagging.
    assign w_unused_pc = ^{bus.PCF[1:0], bus.PCE[1:0]};

    assign w_idx_f = bus.PCF[IDX_W+1:2];
    assign w_tag_f = bus.PCF[31:IDX_W+2];
    assign w_idx_e = bus.PCE[IDX_W+1:2];
    assign w_tag_e = bus.PCE[31:IDX_W+2];

    assign w_hit_f  = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign w_pred_f = w_hit_f && r_cnt[w_idx_f][1];

    assign bus.PredTakenF       = w_pred_f;
    assign bus.PredTargetF      = w_pred_f ? r_target[w_idx_f] : 32'h0;
    assign bus.BranchPredictedE = r_pred_e;

    // Training is gated only by StallE so a branch that is flushed by its own mispredict still trains.
    assign w_upd     = bus.BranchTypeE && !bus.StallE;
    assign w_hit_e   = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
    assign w_wr_data = w_upd && bus.BranchE;

    always_ff @(posedge clk) begin
        if (!CpuRstN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= 2'b01;
            end
            r_pred_d <= 1'b0;
            r_pred_e <= 1'b0;
        end else begin
            // Fetch -> decode
            if (bus.FlushD)
                r_pred_d <= 1'b0;
            else if (!bus.StallD)
                r_pred_d <= w_pred_f;

            // Decode -> execute
            if (bus.FlushE)
                r_pred_e <= 1'b0;
            else if (!bus.StallE)
                r_pred_e <= r_pred_d;

            if (w_upd) begin
                if (w_hit_e) begin
                    r_cnt[w_idx_e] <= bus.BranchE ? sat_inc(r_cnt[w_idx_e])
                                                  : sat_dec(r_cnt[w_idx_e]);
                end else if (bus.BranchE) begin
                    r_valid[w_idx_e] <= 1'b1;
                    r_cnt[w_idx_e]   <= 2'b10;
                end
            end
        end
    end

    // Tag and target carry no reset; they are masked by valid until written.
    always_ff @(posedge clk) begin
        if (CpuRstN && w_wr_data) begin
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= bus.BrTargetE;
        end
    end
endmodule
